// File: rtl/pa_spsram_pkg.sv
// Shared definitions for the parametrised single-port SRAM wrapper:
// controller state encoding, lane geometry and configuration sanity checks.
package pa_spsram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  function automatic int unsigned lane_width(input int unsigned data_width,
                                             input int unsigned we_width);
    return data_width / we_width;
  endfunction

  // Lanes must tile the word exactly and the array needs at least two words.
  function automatic bit cfg_ok(input int unsigned addr_width,
                                input int unsigned data_width,
                                input int unsigned we_width);
    return (addr_width >= 32'd1) && (we_width >= 32'd1) &&
           ((data_width % we_width) == 32'd0);
  endfunction

endpackage

// File: rtl/pa_f_spsram_core.sv
// Behavioural single-port storage array, active-low CEN/GWEN/WEN, read latency 1.
// Q holds the last read word; contents have no reset.
module pa_f_spsram_core
  import pa_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int WE_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q
);

  localparam int LANE  = int'(lane_width(DATA_WIDTH, WE_WIDTH));
  localparam int DEPTH = 32'sd1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] q_r;

  // Storage access: lane-masked write or registered read
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        for (int i = 0; i < WE_WIDTH; i++) begin
          if (!WEN[i]) begin
            mem_r[A][i*LANE +: LANE] <= D[i*LANE +: LANE];
          end
        end
      end else begin
        q_r <= mem_r[A];
      end
    end
  end

  assign Q = q_r;

endmodule

// File: rtl/pa_spsram_ctrl_param.sv
// Single-port SRAM wrapper: post-reset init sweep, access gating, optional
// output register stage and read-valid pulse generation around the storage core.
module pa_spsram_ctrl_param
  import pa_spsram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    WE_WIDTH   = 16,
  parameter bit                    OUT_REG    = 1'b0,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = {DATA_WIDTH{1'b0}}
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  QVLD,
  output logic                  READY,
  output logic                  INIT_DONE
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam state_e                RST_STATE = INIT_EN ? ST_INIT : ST_IDLE;

  if (!cfg_ok(ADDR_WIDTH, DATA_WIDTH, WE_WIDTH)) begin : g_cfg_error
    $error("pa_spsram_ctrl_param: WE_WIDTH must divide DATA_WIDTH and ADDR_WIDTH must be >= 1");
  end

  state_e                state_r, state_s;
  logic [ADDR_WIDTH-1:0] cnt_r, cnt_s;
  logic                  ready_r;
  logic                  vld1_r;
  logic [DATA_WIDTH-1:0] qhold_r;
  logic                  rd_acc_s;

  logic [ADDR_WIDTH-1:0] core_a_s;
  logic                  core_cen_s;
  logic                  core_gwen_s;
  logic [WE_WIDTH-1:0]   core_wen_s;
  logic [DATA_WIDTH-1:0] core_d_s;
  logic [DATA_WIDTH-1:0] core_q_s;

  // Next state, sweep counter and storage-port mux (sweep owns the port in INIT)
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    core_a_s    = A;
    core_cen_s  = 1'b1;
    core_gwen_s = GWEN;
    core_wen_s  = WEN;
    core_d_s    = D;
    rd_acc_s    = 1'b0;
    case (state_r)
      ST_INIT: begin
        core_a_s    = cnt_r;
        core_cen_s  = RST;
        core_gwen_s = 1'b0;
        core_wen_s  = {WE_WIDTH{1'b0}};
        core_d_s    = INIT_VAL;
        cnt_s       = cnt_r + ADDR_WIDTH'(1'b1);
        if (cnt_r == LAST_ADDR) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_IDLE: begin
        // RST gating matters on the reset edge itself, when ready_r may still be high.
        core_cen_s = CEN | ~ready_r | RST;
        rd_acc_s   = ~core_cen_s & GWEN;
        state_s    = ST_IDLE;
      end
      default: begin
        state_s = RST_STATE;
      end
    endcase
  end

  // State register, sweep counter and ready flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= RST_STATE;
      cnt_r   <= {ADDR_WIDTH{1'b0}};
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ready_r <= (state_s == ST_IDLE);
    end
  end

  // First read stage: valid flag and the read-hold copy of core data
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld1_r  <= 1'b0;
      qhold_r <= {DATA_WIDTH{1'b0}};
    end else begin
      vld1_r <= rd_acc_s;
      if (vld1_r) begin
        qhold_r <= core_q_s;
      end else begin
        qhold_r <= qhold_r;
      end
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic vld2_r;

    // Second read stage valid flag
    always_ff @(posedge CLK) begin
      if (RST) begin
        vld2_r <= 1'b0;
      end else begin
        vld2_r <= vld1_r;
      end
    end

    assign Q    = qhold_r;
    assign QVLD = vld2_r;
  end else begin : g_no_out_reg
    assign Q    = vld1_r ? core_q_s : qhold_r;
    assign QVLD = vld1_r;
  end

  // The sweep completing and the port becoming available are the same event.
  assign READY     = ready_r;
  assign INIT_DONE = ready_r;

  pa_f_spsram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .WE_WIDTH   (WE_WIDTH)
  ) u_core (
    .CLK  (CLK),
    .A    (core_a_s),
    .CEN  (core_cen_s),
    .GWEN (core_gwen_s),
    .WEN  (core_wen_s),
    .D    (core_d_s),
    .Q    (core_q_s)
  );

endmodule

// File: tb/tb_pa_spsram_ctrl_param.sv
// Bench for pa_spsram_ctrl_param: three configurations (default, 2-lane with
// output register, no init sweep), directed steps plus randomized traffic vs a word-array model.
module tb_pa_spsram_ctrl_param;

  logic        clk = 1'b0;
  logic        rst0, rst1, rst2;
  logic [8:0]  a;
  logic        gwen;
  logic [15:0] d;
  logic        cen0, cen1, cen2;
  logic [15:0] wen0, wen2;
  logic [1:0]  wen1;
  logic [15:0] q0, q1, q2;
  logic        qvld0, qvld1, qvld2;
  logic        ready0, ready1, ready2;
  logic        done0, done1, done2;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m0 [512];
  logic [15:0] m1 [512];
  logic [15:0] lastq0, lastq1;
  int          n;
  bit          saw;

  always #5 clk = ~clk;

  pa_spsram_ctrl_param #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .WE_WIDTH(16), .OUT_REG(1'b0),
                         .INIT_EN(1'b1), .INIT_VAL(16'h0000)) u0 (
    .CLK(clk), .RST(rst0), .A(a), .CEN(cen0), .GWEN(gwen), .WEN(wen0), .D(d),
    .Q(q0), .QVLD(qvld0), .READY(ready0), .INIT_DONE(done0));

  pa_spsram_ctrl_param #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .WE_WIDTH(2), .OUT_REG(1'b1),
                         .INIT_EN(1'b1), .INIT_VAL(16'hC3C3)) u1 (
    .CLK(clk), .RST(rst1), .A(a), .CEN(cen1), .GWEN(gwen), .WEN(wen1), .D(d),
    .Q(q1), .QVLD(qvld1), .READY(ready1), .INIT_DONE(done1));

  pa_spsram_ctrl_param #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .WE_WIDTH(16), .OUT_REG(1'b0),
                         .INIT_EN(1'b0), .INIT_VAL(16'h0000)) u2 (
    .CLK(clk), .RST(rst2), .A(a), .CEN(cen2), .GWEN(gwen), .WEN(wen2), .D(d),
    .Q(q2), .QVLD(qvld2), .READY(ready2), .INIT_DONE(done2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int inst, input logic c, input logic g, input logic [8:0] ad,
                       input logic [15:0] w, input logic [15:0] dd);
    cen0 = 1'b1; cen1 = 1'b1; cen2 = 1'b1;
    gwen = g; a = ad; d = dd;
    wen0 = w; wen1 = w[1:0]; wen2 = w;
    case (inst)
      0:       cen0 = c;
      1:       cen1 = c;
      default: cen2 = c;
    endcase
  endtask

  task automatic idle;
    drive(0, 1'b1, 1'b1, 9'd0, 16'hFFFF, 16'h0000);
  endtask

  // Waits for READY of one instance; optionally offers a write at sweep cycle 10.
  task automatic wait_ready(input int inst, input bit inject, output int cnt, output bit vld_seen);
    bit got = 1'b0;
    cnt = 0;
    vld_seen = 1'b0;
    while (cnt < 600 && !got) begin
      if (inject && cnt == 9) drive(inst, 1'b0, 1'b0, 9'd7, 16'h0000, 16'hFFFF);
      else idle();
      tick();
      cnt++;
      if ((inst == 0 ? qvld0 : qvld1) !== 1'b0) vld_seen = 1'b1;
      if ((inst == 0 ? ready0 : ready1) === 1'b1) got = 1'b1;
    end
    idle();
  endtask

  // Random traffic; expected output at each cycle is the read issued `lat` cycles earlier.
  task automatic rand_run(input int inst, input int ncyc);
    int          lat = (inst == 0) ? 1 : 2;
    int          lw  = (inst == 0) ? 1 : 8;
    bit          ev_q[$];
    logic [15:0] ed_q[$];
    logic [15:0] last = (inst == 0) ? lastq0 : lastq1;
    bit          ev;
    logic [15:0] ed;
    for (int k = 0; k < lat - 1; k++) begin
      ev_q.push_back(1'b0);
      ed_q.push_back(16'h0000);
    end
    for (int c = 0; c < ncyc + lat - 1; c++) begin
      logic        rc = ($urandom_range(0, 3) == 0) || (c >= ncyc);
      logic        rg = $urandom_range(0, 1) == 1;
      logic [8:0]  ra = 9'($urandom_range(0, 15));
      logic [15:0] rw = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      logic [15:0] rd = 16'($urandom);
      if (!rc && !rg) begin
        for (int b = 0; b < 16; b++) begin
          if (!rw[b / lw]) begin
            if (inst == 0) m0[ra][b] = rd[b];
            else           m1[ra][b] = rd[b];
          end
        end
      end
      ev_q.push_back(!rc && rg);
      ed_q.push_back((inst == 0) ? m0[ra] : m1[ra]);
      drive(inst, rc, rg, ra, rw, rd);
      tick();
      ev = ev_q.pop_front();
      ed = ed_q.pop_front();
      if (ev) last = ed;
      check($sformatf("rnd%0d_qvld_c%0d", inst, c), (inst == 0) ? qvld0 : qvld1, ev);
      check($sformatf("rnd%0d_q_c%0d", inst, c), (inst == 0) ? q0 : q1, last);
    end
    idle();
  endtask

  initial begin
    idle();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) tick();
    check("rst_ready0", ready0, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_qvld0", qvld0, 1'b0);
    check("rst_q0", q0, 16'h0000);
    check("rst_ready1", ready1, 1'b0);
    check("rst_q1", q1, 16'h0000);
    check("rst_ready2", ready2, 1'b0);
    check("rst_done2", done2, 1'b0);
    check("rst_qvld2", qvld2, 1'b0);

    // Sweep on u0/u1 with a dropped write to addr 7 offered at cycle 10
    rst0 = 1'b0; rst1 = 1'b0;
    wait_ready(0, 1'b1, n, saw);
    check("init_ready_edge", n, 512);
    check("init_no_qvld", saw, 1'b0);
    check("init_done0", done0, 1'b1);
    check("init_ready1", ready1, 1'b1);
    check("init_done1", done1, 1'b1);
    for (int i = 0; i < 512; i++) begin
      m0[i] = 16'h0000;
      m1[i] = 16'hC3C3;
    end

    // Post-init reads on default config: latency 1
    drive(0, 1'b0, 1'b1, 9'd0, 16'hFFFF, 16'h0000);   tick();
    check("rd0_qvld", qvld0, 1'b1);   check("rd0_q", q0, 16'h0000);
    drive(0, 1'b0, 1'b1, 9'd255, 16'hFFFF, 16'h0000); tick();
    check("rd255_qvld", qvld0, 1'b1); check("rd255_q", q0, 16'h0000);
    drive(0, 1'b0, 1'b1, 9'd511, 16'hFFFF, 16'h0000); tick();
    check("rd511_qvld", qvld0, 1'b1); check("rd511_q", q0, 16'h0000);
    idle(); tick();
    check("rd_idle_qvld", qvld0, 1'b0);
    drive(0, 1'b0, 1'b1, 9'd7, 16'hFFFF, 16'h0000);   tick();
    check("drop7_q0", q0, 16'h0000);  check("drop7_qvld0", qvld0, 1'b1);
    drive(1, 1'b0, 1'b1, 9'd7, 16'hFFFF, 16'h0000);   tick();
    check("rd7_u1_lat_qvld", qvld1, 1'b0);
    idle(); tick();
    check("rd7_u1_qvld", qvld1, 1'b1); check("rd7_u1_q", q1, 16'hC3C3);

    // Lane-masked writes on the 2-lane instance
    drive(1, 1'b0, 1'b0, 9'd5, 16'h0000, 16'hABCD); tick();
    drive(1, 1'b0, 1'b0, 9'd5, 16'h0002, 16'h1234); tick();
    check("wr_no_qvld", qvld1, 1'b0); check("wr_q_hold", q1, 16'hC3C3);
    drive(1, 1'b0, 1'b1, 9'd5, 16'hFFFF, 16'h0000); tick();
    idle(); tick();
    check("lane_qvld", qvld1, 1'b1); check("lane_q", q1, 16'hAB34);

    // Back-to-back reads with output register
    drive(1, 1'b0, 1'b0, 9'd1, 16'h0000, 16'h0011); tick();
    drive(1, 1'b0, 1'b0, 9'd2, 16'h0000, 16'h0022); tick();
    drive(1, 1'b0, 1'b0, 9'd3, 16'h0000, 16'h0033); tick();
    drive(1, 1'b0, 1'b1, 9'd1, 16'hFFFF, 16'h0000); tick();
    check("b2b_c1_qvld", qvld1, 1'b0);
    drive(1, 1'b0, 1'b1, 9'd2, 16'hFFFF, 16'h0000); tick();
    check("b2b_c2_qvld", qvld1, 1'b1); check("b2b_c2_q", q1, 16'h0011);
    drive(1, 1'b0, 1'b1, 9'd3, 16'hFFFF, 16'h0000); tick();
    check("b2b_c3_qvld", qvld1, 1'b1); check("b2b_c3_q", q1, 16'h0022);
    idle(); tick();
    check("b2b_c4_qvld", qvld1, 1'b1); check("b2b_c4_q", q1, 16'h0033);
    tick();
    check("b2b_c5_qvld", qvld1, 1'b0); check("b2b_hold_q", q1, 16'h0033);

    // One-cycle reset while a read of addr 9 is in flight
    drive(1, 1'b0, 1'b1, 9'd9, 16'hFFFF, 16'h0000); tick();
    idle(); rst1 = 1'b1; tick();
    check("mrst_qvld", qvld1, 1'b0);
    check("mrst_ready", ready1, 1'b0);
    check("mrst_done", done1, 1'b0);
    check("mrst_q", q1, 16'h0000);
    rst1 = 1'b0;
    wait_ready(1, 1'b0, n, saw);
    check("mrst_resweep_len", n, 512);
    check("mrst_no_qvld", saw, 1'b0);
    drive(1, 1'b0, 1'b1, 9'd1, 16'hFFFF, 16'h0000); tick();
    drive(1, 1'b0, 1'b1, 9'd9, 16'hFFFF, 16'h0000); tick();
    check("resweep_a1_q", q1, 16'hC3C3); check("resweep_a1_qvld", qvld1, 1'b1);
    idle(); tick();
    check("resweep_a9_q", q1, 16'hC3C3); check("resweep_a9_qvld", qvld1, 1'b1);
    tick();

    // No-init instance: ready right after reset release
    rst2 = 1'b0; tick();
    check("noinit_ready", ready2, 1'b1);
    check("noinit_done", done2, 1'b1);
    drive(2, 1'b0, 1'b0, 9'd3, 16'h0000, 16'h5A5A); tick();
    check("noinit_wr_qvld", qvld2, 1'b0);
    drive(2, 1'b0, 1'b1, 9'd3, 16'hFFFF, 16'h0000); tick();
    check("noinit_rd_qvld", qvld2, 1'b1); check("noinit_rd_q", q2, 16'h5A5A);
    idle(); tick();
    check("noinit_idle_qvld", qvld2, 1'b0); check("noinit_hold_q", q2, 16'h5A5A);

    // Randomized traffic against the word-array model
    lastq0 = 16'h0000;
    lastq1 = 16'hC3C3;
    rand_run(0, 300);
    rand_run(1, 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
